hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Parametrised hazard detection for the 5-stage pipelined datapath.
- Detects two hazard classes:
  - Load-use data hazards: ID/EX load whose destination feeds the IF/ID instruction.
  - Control hazards: branch/jump opcodes in ID, stalled for a configurable penalty.
- Drives PC hold, IF/ID hold and an ID/EX bubble (flush). Sits beside the IF/ID and ID/EX pipeline registers.

Parameters:
- OPCODE_W, 6, opcode field width.
- REG_W, 5, register-specifier width.
- BRANCH_PENALTY, 2, stall cycles per control hazard (legal range 1..15).
- LOAD_OPCODE_MASK, 6'b100000, instruction is a load when (opcode & mask) == mask and opcode[3] == 0.

Ports:
- Clk in 1 — rising-edge clock.
- Reset in 1 — asynchronous, active-low reset.
- IFID_Opcode in OPCODE_W — opcode of the instruction in ID.
- IFID_Rs in REG_W — rs field of the instruction in ID.
- IFID_Rt in REG_W — rt field of the instruction in ID.
- IDEX_MemRead in 1 — instruction in EX is a load.
- IDEX_Rt in REG_W — load destination register in EX.
- Stall out 1 — hold IF/ID register.
- PCStall out 1 — hold PC.
- Flush out 1 — zero the ID/EX control bits (insert bubble).
- Busy out 1 — FSM not in IDLE.

Behaviour:
- Reset (Reset==0, asynchronous):
  - State = IDLE, counter = 0.
  - Stall, PCStall, Flush and Busy read 0 while Reset is low and on the first cycle after release.
- Outputs are a function of the current state and the current inputs (Mealy), so a hazard is covered in the same cycle it is detected.
- Definitions:
  - luHaz = IDEX_MemRead && IDEX_Rt != 0 && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt).
  - brOp = opcode ∈ {000100 beq, 000101 bne, 000010 j, 000011 jal}.
- IDLE:
  - luHaz: Stall=PCStall=Flush=1; next state LU.
  - else brOp: Stall=PCStall=1, Flush=0; counter loads BRANCH_PENALTY-1; next state BR. If BRANCH_PENALTY==1, return to IDLE after this cycle (stall is one cycle).
  - else all outputs 0.
- LU (one cycle):
  - Outputs all 0; the load has advanced and the dependent instruction proceeds.
  - If the held instruction is also brOp, enter BR exactly as from IDLE. Branch stall is asserted this cycle and the counter loads.
  - Precedence: load-use first, then branch. The two stalls never overlap.
- BR:
  - Stall=PCStall=1, Flush=1. Flush bubbles ID/EX so the branch issues exactly once.
  - Counter decrements each cycle; at counter==0 → IDLE, outputs deasserted on the following cycle.
  - Total branch stall = BRANCH_PENALTY cycles.
  - Inputs are ignored while in BR; no new detection.
- Busy = (state != IDLE).
- IDEX_Rt == 0: never a hazard ($zero).
- Back-to-back branches: the second branch is detected in IDLE the cycle after BR exits. No missed or merged stalls.
- Reset asserted mid-BR or mid-LU: immediate return to IDLE, all outputs 0, counter cleared.
- Counter width = clog2(BRANCH_PENALTY+1). No wrap: the counter is only decremented when nonzero.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Extra outputs LuStallCount[15:0] and BrStallCount[15:0].
  - Each increments once per cycle the corresponding stall is asserted.
  - Both saturate at 16'hFFFF and are cleared by Reset.
- Undefined: ports and counters are absent; core behaviour identical.

Decomposition:
- Shared package hazard_pkg holds:
  - Opcode constants OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LW.
  - State encoding (IDLE=2'd0, LU=2'd1, BR=2'd2).
  - Default widths.
- One natural sub-module: stall_counter. Loadable down-counter with load, dec and zero flag, parametrised width; also reused for the statistics counters in saturating-up mode.

Test Plan:
- Load-use detection: IDEX_MemRead=1, IDEX_Rt=5'd8, IFID_Rs=5'd8 → Stall=PCStall=Flush=1 for exactly 1 cycle, then all 0.
- $zero is never a hazard: IDEX_MemRead=1, IDEX_Rt=0, IFID_Rs=0 → no stall, Busy stays 0.
- Branch penalty: BRANCH_PENALTY=2, IFID_Opcode=6'b000100 → Stall/PCStall high for 2 consecutive cycles, Flush high on the 2nd, Busy high 1 cycle.
- Load-use then branch: load-use hazard with IFID_Opcode=beq → 1 load-use cycle, then 2 branch cycles, 3 total stall cycles with no gap.
- Reset mid-branch: BRANCH_PENALTY=4, pull Reset low in the 2nd stall cycle → all outputs 0 immediately; after release, a new bne stalls the full 4 cycles.
- Statistics (HAZARD_STATS_EN defined): 3 branches at penalty 2 and 1 load-use → BrStallCount=6, LuStallCount=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: opcodes, FSM encoding and default widths.
package hazard_pkg;

    localparam int OPCODE_W_DEF       = 6;
    localparam int REG_W_DEF          = 5;
    localparam int BRANCH_PENALTY_DEF = 2;

    localparam logic [5:0] LOAD_MASK_DEF = 6'b100000;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_LW  = 6'b100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LU   = 2'd1,
        BR   = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_unit_stall_counter.sv
// Loadable counter: down-counts to zero (no wrap) or, with SAT_UP, up-counts and saturates.
module stall_counter #(
    parameter int W      = 2,
    parameter bit SAT_UP = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (step) begin
            if (SAT_UP) begin
                if (value != '1)
                    value <= value + 1'b1;
            end else if (value != '0) begin
                value <= value - 1'b1;
            end
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/hazard_unit.sv
// Load-use and control hazard detection for the 5-stage pipeline (Mealy outputs).
// Optional stall statistics counters are enabled with HAZARD_STATS_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int                  OPCODE_W         = OPCODE_W_DEF,
    parameter int                  REG_W            = REG_W_DEF,
    parameter int                  BRANCH_PENALTY   = BRANCH_PENALTY_DEF,
    parameter logic [OPCODE_W-1:0] LOAD_OPCODE_MASK = OPCODE_W'(LOAD_MASK_DEF)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] IFID_Opcode,
    input  logic [REG_W-1:0]    IFID_Rs,
    input  logic [REG_W-1:0]    IFID_Rt,
    input  logic                IDEX_MemRead,
    input  logic [REG_W-1:0]    IDEX_Rt,
    output logic                Stall,
    output logic                PCStall,
    output logic                Flush,
    output logic                Busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]         LuStallCount,
    output logic [15:0]         BrStallCount
`endif
);

    localparam int                CNT_W     = $clog2(BRANCH_PENALTY + 1);
    localparam logic [CNT_W-1:0]  BR_RELOAD = CNT_W'(BRANCH_PENALTY - 1);
    localparam logic [OPCODE_W-1:0] LW_OP   = OPCODE_W'(OP_LW);

    if (BRANCH_PENALTY < 1 || BRANCH_PENALTY > 15) begin : g_bad_penalty
        $error("hazard_unit: BRANCH_PENALTY must be in 1..15");
    end
    // A mask with bit 3 set can never match, since loads require opcode[3]==0.
    if (((LW_OP & LOAD_OPCODE_MASK) != LOAD_OPCODE_MASK) || LW_OP[3]) begin : g_bad_mask
        $error("hazard_unit: LOAD_OPCODE_MASK does not classify lw as a load");
    end

    state_t           state, next;
    logic             armed;
    logic             lu_haz, br_op;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign lu_haz = IDEX_MemRead && (IDEX_Rt != '0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
    assign br_op  = (IFID_Opcode == OPCODE_W'(OP_BEQ)) || (IFID_Opcode == OPCODE_W'(OP_BNE)) ||
                    (IFID_Opcode == OPCODE_W'(OP_J))   || (IFID_Opcode == OPCODE_W'(OP_JAL));

    // armed keeps outputs quiet for the first cycle after reset release.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        next     = state;
        Stall    = 1'b0;
        PCStall  = 1'b0;
        Flush    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (armed) begin
            unique case (state)
                IDLE, LU: begin
                    if (state == IDLE && lu_haz) begin
                        Stall   = 1'b1;
                        PCStall = 1'b1;
                        Flush   = 1'b1;
                        next    = LU;
                    end else if (br_op) begin
                        // First branch stall cycle; BR covers the remaining PENALTY-1.
                        Stall    = 1'b1;
                        PCStall  = 1'b1;
                        cnt_load = 1'b1;
                        next     = (BRANCH_PENALTY == 1) ? IDLE : BR;
                    end else begin
                        next = IDLE;
                    end
                end
                BR: begin
                    Stall   = 1'b1;
                    PCStall = 1'b1;
                    Flush   = 1'b1;
                    cnt_dec = 1'b1;
                    if (cnt_zero || cnt_val == CNT_W'(1))
                        next = IDLE;
                end
                default: next = IDLE;
            endcase
        end
    end

    assign Busy = (state != IDLE);

    stall_counter #(.W(CNT_W), .SAT_UP(1'b0)) u_br_cnt (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .load_val (BR_RELOAD),
        .step     (cnt_dec),
        .value    (cnt_val),
        .zero     (cnt_zero)
    );

`ifdef HAZARD_STATS_EN
    logic       lu_stall, br_stall;
    logic [1:0] stats_zero_unused;

    // Flush in IDLE only happens on a load-use stall; any other stall is a branch stall.
    assign lu_stall = Flush && (state == IDLE);
    assign br_stall = Stall && !lu_stall;

    stall_counter #(.W(16), .SAT_UP(1'b1)) u_lu_stats (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (1'b0),
        .load_val (16'h0000),
        .step     (lu_stall),
        .value    (LuStallCount),
        .zero     (stats_zero_unused[0])
    );

    stall_counter #(.W(16), .SAT_UP(1'b1)) u_br_stats (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (1'b0),
        .load_val (16'h0000),
        .step     (br_stall),
        .value    (BrStallCount),
        .zero     (stats_zero_unused[1])
    );
`endif

endmodule
